imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch-to-imem interface.
- Accepts a two-word read request (addr0, addr1, ren) from the fetch unit.
- Returns both instruction words together with their PCs after a fixed, parameterised latency.
- Provides a one-word-per-cycle load port for the bench or boot loader to preload the program image, and a flush input that kills in-flight responses on redirect.

Parameters:
XLEN, 32, data/address width (from core_pkg)
DEPTH_WORDS, 1024, number of 32-bit instruction words stored
LATENCY, 1, cycles from an accepted request to imem_valid; legal range 1..4
NOP_INSTR, 32'hD503201F, word returned for out-of-range addresses

Ports:
clk  in  1  core clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high; clears pipeline state
imem_ren  in  1  read request strobe from fetch
imem_addr0  in  XLEN  byte address of first instruction
imem_addr1  in  XLEN  byte address of second instruction
flush  in  1  kills all in-flight responses (driven from redirect)
load_en  in  1  write strobe for program preload
load_addr  in  XLEN  byte address for preload write
load_data  in  XLEN  word written on load_en
imem_rdata0  out  XLEN  instruction word at addr0
imem_rdata1  out  XLEN  instruction word at addr1
imem_pc  out  XLEN x2  imem_pc[0]=addr0, imem_pc[1]=addr1 of the returned request
imem_valid  out  1  response valid, single-cycle pulse per request
imem_err  out  1  qualifies imem_valid; asserted if either address was misaligned or out of range

Behaviour:
- Storage: DEPTH_WORDS x XLEN array, two independent read ports plus one write port; array contents are not reset.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] is ignored for indexing.
- Request acceptance: a request is accepted on every rising edge with imem_ren=1. There is no back-pressure, and a new request may be accepted every cycle.
- Latency: a request accepted at edge N produces imem_valid=1 during the cycle after edge N+LATENCY-1. With LATENCY=1, the response is visible in the cycle immediately after the request cycle.
- Pipeline: LATENCY stages, each holding {valid, err, pc0, pc1, data0, data1}. Array reads are sampled at acceptance; later stages only shift. Output ports are driven from the final stage.
- Out of range: word index >= DEPTH_WORDS, or address bits above the index range nonzero. That word returns NOP_INSTR and imem_err=1.
- Misaligned: addr[1:0] != 0. The word is still returned from the truncated index and imem_err=1.
- imem_err is evaluated per request as the OR over both addresses. It is meaningful only when imem_valid=1 and reads 0 otherwise.
- addr1 is used as supplied; the block does not require addr1 = addr0 + 4.
- Load port: on an edge with load_en=1, mem[load_addr index] <= load_data. Out-of-range or misaligned load addresses are silently dropped.
- Read/write collision: a read and a load to the same word on the same edge returns the OLD data.
- flush=1 at an edge: every pipeline stage's valid bit clears. A request with imem_ren=1 on the same edge is still accepted, because fetch drops ren during redirect anyway.
- Reset (asynchronous, any time, including mid-operation): all stage valid/err bits and all output data/pc are cleared to 0. After deassertion, the first response appears LATENCY cycles after the first accepted request.
- Reset values: imem_valid=0, imem_err=0, imem_rdata0/1=0, imem_pc[0]/[1]=0.
- When imem_valid=0, data outputs hold their last values and carry no meaning.

Decomposition:
- core_pkg: XLEN, FETCH_WIDTH, NOP_INSTR constant, and the typedef imem_resp_t {valid, err, pc[2], data[2]}.
- One sub-module, imem_resp_pipe: a parameterised LATENCY-deep shift register of imem_resp_t with async reset and a flush input.
- Top level holds the array, the address decode/error checks and the load port.

Test Plan:
- Preload mem[0..3]=0x11,0x22,0x33,0x44; with LATENCY=1 assert ren with addr0=0x0, addr1=0x4 for one cycle -> next cycle imem_valid=1, rdata0=0x11, rdata1=0x22, imem_pc={0x0,0x4}, err=0. The following cycle imem_valid=0.
- Issue back-to-back requests 0x0/0x4 then 0x8/0xC at LATENCY=3 -> valid pulses at cycles 3 and 4 carry (0x11,0x22) and then (0x33,0x44), in order with no gaps.
- At LATENCY=2, issue a request, then assert flush on the next edge -> no imem_valid for that request. A request issued on the flush edge still returns 2 cycles later.
- Request addr0=0xFFC, addr1=0x1000 with DEPTH_WORDS=1024 -> rdata0=mem[1023], rdata1=0xD503201F, err=1. Request addr0=0x2 -> err=1 and rdata0=mem[0].
- Same edge: load_en to 0x8 with 0xAA and ren with addr0=0x8 -> returned rdata0=0x33 (old data). A repeat read returns 0xAA.
- Assert reset asynchronously mid-cycle while two requests are in flight at LATENCY=2 -> outputs go to 0 immediately and no stale valid appears after release.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared fetch-interface widths, NOP word and the imem response record.
package core_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_WIDTH = 2;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'hD503201F;
    typedef struct packed {
        logic                              valid;
        logic                              err;
        logic [FETCH_WIDTH-1:0][XLEN-1:0] pc;
        logic [FETCH_WIDTH-1:0][XLEN-1:0] data;
    } imem_resp_t;
endpackage

// File: rtl/imem_resp_pipe.sv
// imem_resp_pipe: LATENCY-deep response shift register with async reset and flush.
//   clk, reset : clock, async active-high reset (clears every stage)
//   flush      : kills all in-flight entries; a new entry on the same edge survives
//   req_i      : response captured at request acceptance
//   resp_o     : final stage, drives the responder outputs
module imem_resp_pipe
    import core_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  imem_resp_t req_i,
    output imem_resp_t resp_o
);
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        imem_resp_t src, stage_d, stage_q;
        if (s == 0) begin : g_head
            assign src = req_i;
        end else begin : g_body
            assign src = g_stage[s-1].stage_q;
        end
        // Payload only moves with a valid entry so outputs hold their last value when idle.
        always_comb begin
            stage_d       = src.valid ? src : stage_q;
            stage_d.valid = src.valid && (s == 0 || !flush);
            stage_d.err   = stage_d.valid && src.err;
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) stage_q <= '0;
            else       stage_q <= stage_d;
        end
    end
    assign resp_o = g_stage[LATENCY-1].stage_q;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: two-word instruction memory with fixed-latency responses and a preload port.
//   clk, reset               : clock, async active-high reset of the response pipeline
//   imem_ren, imem_addr0/1   : two-word read request from fetch
//   flush                    : drops in-flight responses on redirect
//   load_en/addr/data        : one-word-per-cycle program preload
//   imem_rdata0/1, imem_pc   : returned words and their addresses
//   imem_valid, imem_err     : one-cycle response pulse; err flags misaligned/out-of-range
module imem_responder
    import core_pkg::*;
#(
    parameter int               DEPTH_WORDS = 1024,
    parameter int               LATENCY     = 1,
    parameter logic [XLEN-1:0]  NOP_INSTR   = core_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_ren,
    input  logic [XLEN-1:0]       imem_addr0,
    input  logic [XLEN-1:0]       imem_addr1,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [XLEN-1:0]       load_addr,
    input  logic [XLEN-1:0]       load_data,
    output logic [XLEN-1:0]       imem_rdata0,
    output logic [XLEN-1:0]       imem_rdata1,
    output logic [1:0][XLEN-1:0]  imem_pc,
    output logic                  imem_valid,
    output logic                  imem_err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [FETCH_WIDTH-1:0][XLEN-1:0] addr;
    imem_resp_t req, resp;

    function automatic logic [IW-1:0] word_idx(input logic [XLEN-1:0] a);
        return a[IW+1:2];
    endfunction

    // Covers both stray high bits and indices past a non-power-of-two depth.
    function automatic logic out_of_range(input logic [XLEN-1:0] a);
        return (|a[XLEN-1:IW+2]) || ({1'b0, a[IW+1:2]} >= (IW+1)'(DEPTH_WORDS));
    endfunction

    assign addr = {imem_addr1, imem_addr0};

    // The array is read combinationally here and captured into stage 0, so a load on
    // the same edge is not yet visible: collisions return the old word.
    always_comb begin
        req       = '0;
        req.valid = imem_ren;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            req.pc[i]   = addr[i];
            req.data[i] = out_of_range(addr[i]) ? NOP_INSTR : mem[word_idx(addr[i])];
            req.err     = req.err || out_of_range(addr[i]) || (|addr[i][1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && !out_of_range(load_addr) && load_addr[1:0] == 2'b00)
            mem[word_idx(load_addr)] <= load_data;
    end

    imem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .req_i  (req),
        .resp_o (resp)
    );

    assign imem_valid  = resp.valid;
    assign imem_err    = resp.err;
    assign imem_rdata0 = resp.data[0];
    assign imem_rdata1 = resp.data[1];
    assign imem_pc     = resp.pc;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of three responders (LATENCY 1, 2, 3) sharing one stimulus.
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk, reset, ren, flush, load_en;
    logic [31:0] a0, a1, load_addr, load_data;
    logic [31:0] rd0 [3];
    logic [31:0] rd1 [3];
    logic [1:0][31:0] pc [3];
    logic        vld [3];
    logic        err [3];
    int          checks = 0;
    int          failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(.DEPTH_WORDS(1024), .LATENCY(g + 1)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .imem_ren    (ren),
            .imem_addr0  (a0),
            .imem_addr1  (a1),
            .flush       (flush),
            .load_en     (load_en),
            .load_addr   (load_addr),
            .load_data   (load_data),
            .imem_rdata0 (rd0[g]),
            .imem_rdata1 (rd1[g]),
            .imem_pc     (pc[g]),
            .imem_valid  (vld[g]),
            .imem_err    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [129:0] obs(input int k);
        return {vld[k], err[k], rd0[k], rd1[k], pc[k][0], pc[k][1]};
    endfunction

    function automatic logic [129:0] r(input logic v, e, input logic [31:0] d0, d1, p0, p1);
        return {v, e, d0, d1, p0, p1};
    endfunction

    task automatic check(input string tag, input logic [129:0] got, exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] x0, x1);
        ren = 1'b1; a0 = x0; a1 = x1;
        step();
        ren = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ren = 1'b0; flush = 1'b0; load_en = 1'b0;
        a0 = '0; a1 = '0; load_addr = '0; load_data = '0;
        #1 reset = 1'b1;
        step();
        for (int k = 0; k < 3; k++) check($sformatf("reset_l%0d", k + 1), obs(k), '0);
        reset = 1'b0;
        load(32'h0, 32'h11); load(32'h4, 32'h22); load(32'h8, 32'h33); load(32'hC, 32'h44);
        load(32'hFFC, 32'h3FF);
        load(32'h1000, 32'hBAD);
        load(32'h5, 32'hBAD);

        issue(32'h0, 32'h4);
        check("t1_l1", obs(0), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        check("t1_l2_early", {129'b0, vld[1]}, '0);
        step();
        check("t1_l1_pulse", {129'b0, vld[0]}, '0);
        check("t1_l2", obs(1), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        check("t1_l3_early", {129'b0, vld[2]}, '0);
        step();
        check("t1_l3", obs(2), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        step();

        issue(32'h0, 32'h4);
        issue(32'h8, 32'hC);
        step();
        check("t2_first", obs(2), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        step();
        check("t2_second", obs(2), r(1, 0, 32'h33, 32'h44, 32'h8, 32'hC));
        step();
        check("t2_idle", {129'b0, vld[2]}, '0);

        issue(32'h8, 32'hC);
        flush = 1'b1;
        issue(32'h0, 32'h4);
        flush = 1'b0;
        check("t3_killed", {129'b0, vld[1]}, '0);
        check("t3_l1_new", obs(0), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        step();
        check("t3_l2_new", obs(1), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        step();
        check("t3_l2_idle", {129'b0, vld[1]}, '0);
        step(); step();

        issue(32'hFFC, 32'h1000);
        check("t4_edge", obs(0), r(1, 1, 32'h3FF, NOP, 32'hFFC, 32'h1000));
        issue(32'h2, 32'h4);
        check("t4_misal", obs(0), r(1, 1, 32'h11, 32'h22, 32'h2, 32'h4));
        issue(32'h0, 32'h8000_0000);
        check("t4_high", obs(0), r(1, 1, 32'h11, NOP, 32'h0, 32'h8000_0000));
        step();
        check("t4_err_idle", {128'b0, vld[0], err[0]}, '0);
        step(); step();

        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hAA;
        issue(32'h8, 32'h0);
        load_en = 1'b0;
        check("t5_old", obs(0), r(1, 0, 32'h33, 32'h11, 32'h8, 32'h0));
        issue(32'h8, 32'h0);
        check("t5_new", obs(0), r(1, 0, 32'hAA, 32'h11, 32'h8, 32'h0));
        step(); step(); step();

        issue(32'h0, 32'h4);
        issue(32'h8, 32'hC);
        check("t6_inflight", obs(1), r(1, 0, 32'h11, 32'h22, 32'h0, 32'h4));
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("t6_async_l%0d", k + 1), obs(k), '0);
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_stale_%0d", i), {128'b0, vld[1], vld[2]}, '0);
        end
        issue(32'hC, 32'h8);
        check("t6_lat_early", {129'b0, vld[1]}, '0);
        step();
        check("t6_after", obs(1), r(1, 0, 32'h44, 32'hAA, 32'hC, 32'h8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
